// File: rtl/dat_xfer_seq_if.sv
// Handshake and status bundle between the data-path receiver/card pins and the transfer sequencer.
// Master drives the start/receiver/pin inputs; slave (the sequencer) returns running/done/timeout.
interface dat_xfer_seq_if;
    logic [3:0] timeout_bits_i;
    logic       start_read_i;
    logic       start_busy_i;
    logic       start_bit_i;
    logic       block_done_i;
    logic       last_block_i;
    logic       dat0_i;
    logic       abort_i;
    logic       running_o;
    logic       done_o;
    logic       timeout_o;

    modport master (
        output timeout_bits_i, start_read_i, start_busy_i, start_bit_i,
        output block_done_i, last_block_i, dat0_i, abort_i,
        input  running_o, done_o, timeout_o
    );

    modport slave (
        input  timeout_bits_i, start_read_i, start_busy_i, start_bit_i,
        input  block_done_i, last_block_i, dat0_i, abort_i,
        output running_o, done_o, timeout_o
    );
endinterface

// File: rtl/dat_xfer_seq.sv
// Data-transfer sequencer: read start-bit/block tracking and write-busy release, with data timeout.
// Latency: done/timeout are Mealy pulses in the deciding cycle; no backpressure, every pulse is single-cycle.
module dat_xfer_seq #(
    parameter int MaxTimeoutBits = 14,
    parameter int CntWidth       = 28
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dat_xfer_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2,
        WR_BUSY = 2'd3
    } state_e;

    localparam logic [3:0] MaxCode = 4'(MaxTimeoutBits);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [3:0]          code_q, code_d;
    logic                hi_q, hi_d;

    logic [3:0]          code_clamped;
    logic [CntWidth-1:0] thresh;
    logic                at_thresh;
    logic                busy_release;

    assign code_clamped = (bus.timeout_bits_i > MaxCode) ? MaxCode : bus.timeout_bits_i;
    assign thresh       = CntWidth'(1) << ({1'b0, code_q} + 5'd13);
    assign at_thresh    = (cnt_q == thresh);
    // hi_q remembers dat0 high in the previous WR_BUSY cycle; a low cycle clears it
    assign busy_release = bus.dat0_i && hi_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            hi_q    <= hi_d;
        end
    end

    // Counter defaults to 0, so every entry into a timed state starts at cycle 0
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        code_d  = code_q;
        hi_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.abort_i && bus.start_read_i) begin
                    state_d = RD_WAIT;
                    code_d  = code_clamped;
                end else if (!bus.abort_i && bus.start_busy_i) begin
                    state_d = WR_BUSY;
                    code_d  = code_clamped;
                end
            end
            RD_WAIT: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (bus.start_bit_i) begin
                    state_d = RD_DATA;
                end else if (at_thresh) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            RD_DATA: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (bus.block_done_i) begin
                    state_d = bus.last_block_i ? IDLE : RD_WAIT;
                end
            end
            WR_BUSY: begin
                if (bus.abort_i || busy_release || at_thresh) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                    hi_d  = bus.dat0_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.running_o = (state_q != IDLE);
        bus.done_o    = 1'b0;
        bus.timeout_o = 1'b0;
        if (!bus.abort_i) begin
            case (state_q)
                RD_WAIT: bus.timeout_o = !bus.start_bit_i && at_thresh;
                RD_DATA: bus.done_o    = bus.block_done_i && bus.last_block_i;
                WR_BUSY: begin
                    bus.done_o    = busy_release;
                    bus.timeout_o = !busy_release && at_thresh;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dat_xfer_seq.sv
// Randomized and directed bench for dat_xfer_seq; expected end cycle and outcome come from a transaction-level model.
module tb_dat_xfer_seq;
    localparam int MAXB = 1;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    // Per-cycle stimulus, bit 0 start_bit, 1 block_done, 2 last_block, 3 dat0, 4 abort
    logic [4:0] stim[];
    int         end_cyc;
    int         kind;   // 0 aborted, 1 done, 2 timeout

    dat_xfer_seq_if bus ();

    dat_xfer_seq #(
        .MaxTimeoutBits(MAXB),
        .CntWidth      (15)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic int thr(input logic [3:0] code);
        int c;
        c = (int'(code) > MAXB) ? MAXB : int'(code);
        return 1 << (c + 13);
    endfunction

    function automatic logic rnd_pct(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    // Read transfer: block b waits s cycles for its start bit, then d data cycles before block_done.
    task automatic build_read(input int nblk, input int t, input int s_fix, input int d_fix,
                              input int to_blk, input bit noise);
        int s[4];
        int d[4];
        int len;
        int pos;
        len = t + 4;
        for (int b = 0; b < nblk; b++) begin
            s[b] = (s_fix >= 0) ? s_fix : int'($urandom_range(0, 40));
            d[b] = (d_fix >= 0) ? d_fix : int'($urandom_range(0, 30));
            len += s[b] + d[b] + 2;
        end
        stim = new[len];
        foreach (stim[i]) stim[i] = noise ? {1'b0, rnd_pct(50), rnd_pct(50), 2'b00} : 5'b0;
        pos = 0;
        for (int b = 0; b < nblk; b++) begin
            if (b == to_blk) begin
                if (noise) for (int i = pos; i <= pos + t; i++) stim[i][1] = rnd_pct(10);
                end_cyc = pos + t;
                kind    = 2;
                return;
            end
            if (noise) for (int i = pos; i < pos + s[b]; i++) stim[i][1] = rnd_pct(10);
            stim[pos + s[b]][0] = 1'b1;
            if (noise) for (int i = pos + s[b] + 1; i <= pos + s[b] + d[b]; i++) stim[i][0] = rnd_pct(10);
            stim[pos + s[b] + 1 + d[b]][1] = 1'b1;
            stim[pos + s[b] + 1 + d[b]][2] = (b == nblk - 1);
            if (b == nblk - 1) begin
                end_cyc = pos + s[b] + 1 + d[b];
                kind    = 1;
                return;
            end
            pos += s[b] + d[b] + 2;
        end
    endtask

    task automatic build_busy(input int t, input int phigh, input bit noise);
        stim = new[t + 4];
        foreach (stim[i])
            stim[i] = noise ? {1'b0, rnd_pct(phigh), rnd_pct(50), rnd_pct(20), rnd_pct(20)}
                            : {1'b0, rnd_pct(phigh), 3'b000};
    endtask

    // Busy release is the first pair of consecutive high samples inside the window, else timeout at t.
    task automatic resolve_busy(input int t);
        end_cyc = t;
        kind    = 2;
        for (int k = 1; k <= t; k++) begin
            if (stim[k][3] && stim[k-1][3]) begin
                end_cyc = k;
                kind    = 1;
                break;
            end
        end
    endtask

    task automatic apply_abort(input int a);
        if (a <= end_cyc) begin
            stim[a][4] = 1'b1;
            end_cyc    = a;
            kind       = 0;
        end
    endtask

    task automatic drive_idle();
        bus.start_read_i = 1'b0;
        bus.start_busy_i = 1'b0;
        bus.start_bit_i  = 1'b0;
        bus.block_done_i = 1'b0;
        bus.last_block_i = 1'b0;
        bus.dat0_i       = 1'b0;
        bus.abort_i      = 1'b0;
    endtask

    task automatic run_xfer(input bit rd, input logic [3:0] code, input logic [3:0] code_mid,
                            input bit noise, input bit no_wait, input string tag);
        logic [2:0] exp;
        if (!no_wait) @(negedge clk);
        drive_idle();
        bus.timeout_bits_i = code;
        bus.start_read_i   = rd;
        bus.start_busy_i   = rd ? (noise && rnd_pct(50)) : 1'b1;
        #1 chk({tag, "_start"}, {bus.running_o, bus.done_o, bus.timeout_o}, 3'b000);
        for (int c = 0; c <= end_cyc + 1; c++) begin
            @(negedge clk);
            bus.timeout_bits_i = code_mid;
            bus.start_read_i   = noise && (c <= end_cyc) && rnd_pct(12);
            bus.start_busy_i   = noise && (c <= end_cyc) && rnd_pct(12);
            if (c <= end_cyc)
                {bus.abort_i, bus.dat0_i, bus.last_block_i, bus.block_done_i, bus.start_bit_i} = stim[c];
            else
                {bus.abort_i, bus.dat0_i, bus.last_block_i, bus.block_done_i, bus.start_bit_i} = 5'b0;
            #1;
            exp = {c <= end_cyc, (c == end_cyc) && (kind == 1), (c == end_cyc) && (kind == 2)};
            chk(tag, {bus.running_o, bus.done_o, bus.timeout_o}, exp);
        end
    endtask

    initial begin
        int        typ;
        logic [3:0] code;
        logic [3:0] code_mid;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        bus.timeout_bits_i = 4'd0;
        drive_idle();
        #1 chk("reset_outputs", {bus.running_o, bus.done_o, bus.timeout_o}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First start right after reset release; read times out at T with no start bit
        build_read(1, thr(0), -1, -1, 0, 1'b1);
        run_xfer(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, "rd_timeout_n0");

        // Start bit exactly at T wins over the timeout
        build_read(1, thr(0), thr(0), 5, -1, 1'b1);
        run_xfer(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "rd_sbit_at_t");

        // Three blocks, each waiting 5000 cycles: total wait exceeds T so the count must restart
        build_read(3, thr(0), 5000, 10, -1, 1'b1);
        run_xfer(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, "rd_3blk");

        // Code 15 clamps to MAXB and is held although the input drops to 0
        build_busy(thr(15), 0, 1'b0);
        resolve_busy(thr(15));
        run_xfer(1'b0, 4'd15, 4'd0, 1'b0, 1'b0, "busy_clamp_to");

        // Busy released by H,L,H,H starting at cycle 100: completion on the second H of the pair
        build_busy(thr(0), 0, 1'b0);
        stim[100][3] = 1'b1;
        stim[102][3] = 1'b1;
        stim[103][3] = 1'b1;
        resolve_busy(thr(0));
        run_xfer(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "busy_glitch");

        // Abort while waiting for the first start bit
        build_read(1, thr(0), 100, 5, -1, 1'b0);
        apply_abort(50);
        run_xfer(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "rd_abort50");

        // Abort in IDLE blocks a start pulse
        @(negedge clk);
        bus.abort_i      = 1'b1;
        bus.start_read_i = 1'b1;
        @(negedge clk);
        drive_idle();
        #1 chk("idle_abort_block", {bus.running_o, bus.done_o, bus.timeout_o}, 3'b000);

        // Reset in WR_BUSY discards the transfer even with dat0 high during reset
        @(negedge clk);
        bus.timeout_bits_i = 4'd0;
        bus.start_busy_i   = 1'b1;
        @(negedge clk);
        bus.start_busy_i = 1'b0;
        repeat (30) @(negedge clk);
        #1 chk("busy_before_rst", {bus.running_o, bus.done_o, bus.timeout_o}, 3'b100);
        #1 rst = 1'b1;
        #1 chk("rst_async", {bus.running_o, bus.done_o, bus.timeout_o}, 3'b000);
        bus.dat0_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 chk("rst_hold", {bus.running_o, bus.done_o, bus.timeout_o}, 3'b000);
        end
        rst = 1'b0;
        @(negedge clk);
        #1 chk("rst_release", {bus.running_o, bus.done_o, bus.timeout_o}, 3'b000);
        build_read(2, thr(0), -1, -1, -1, 1'b1);
        run_xfer(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, "rd_after_rst");

        for (int it = 0; it < 40; it++) begin
            typ      = int'($urandom_range(0, 1));
            code     = 4'($urandom_range(0, 15));
            code_mid = 4'($urandom_range(0, 15));
            if (typ == 0) build_read(int'($urandom_range(1, 3)), thr(code), -1, -1, -1, 1'b1);
            else begin
                build_busy(thr(code), int'($urandom_range(20, 60)), 1'b1);
                resolve_busy(thr(code));
            end
            if (rnd_pct(25)) apply_abort(int'($urandom_range(0, end_cyc)));
            run_xfer(typ == 0, code, code_mid, 1'b1, 1'b0, (typ == 0) ? "rnd_rd" : "rnd_busy");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
